// File: rtl/encoder_pkg.sv
// encoder_pkg: shared state encoding and size limit for priority_encoder_hs.
package encoder_pkg;
    typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;
    localparam int MAX_N = 32;
endpackage

// File: rtl/priority_encoder_hs_prio_find.sv
// prio_find: first set bit of vector at or after start, wrapping from N-1 to 0.
module prio_find #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vector,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] index
);
    always_comb begin
        int p;
        found = 1'b0;
        index = '0;
        p     = 0;
        // Walk offsets from farthest to nearest so the nearest hit is written last.
        for (int k = N - 1; k >= 0; k--) begin
            p = int'(start) + k;
            if (p >= N) p = p - N;
            if (vector[p]) begin
                found = 1'b1;
                index = W'(p);
            end
        end
    end
endmodule

// File: rtl/priority_encoder_hs.sv
// priority_encoder_hs: sticky-pending N:log2(N) encoder with valid/ack handshake.
// Define ROTATE_PRIORITY_EN for round-robin priority; default is fixed (bit 0 highest).
module priority_encoder_hs
    import encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         ack,
    output logic [W-1:0] idx,
    output logic         valid,
    output logic [N-1:0] pending
);
    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("priority_encoder_hs: N out of range");
    end

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   w_clr;
    logic [W-1:0]   r_idx;
    logic [W-1:0]   w_start;
    logic [W-1:0]   w_index;
    logic           w_found;
    logic           w_ack;
    logic           w_grant;

    assign w_ack   = (r_state == VALID) && ack;
    assign w_grant = (r_state == IDLE) && en && w_found;
    assign w_clr   = w_ack ? ({{(N-1){1'b0}}, 1'b1} << r_idx) : '0;

`ifdef ROTATE_PRIORITY_EN
    logic [W-1:0] r_last;
    always_ff @(posedge clk) begin
        if (rst)        r_last <= W'(N - 1);
        else if (w_ack) r_last <= r_idx;
    end
    assign w_start = (r_last == W'(N - 1)) ? '0 : r_last + 1'b1;
`else
    assign w_start = '0;
`endif

    prio_find #(.N(N)) u_find (
        .vector (r_pending),
        .start  (w_start),
        .found  (w_found),
        .index  (w_index)
    );

    always_comb begin
        w_next = (r_state == IDLE) ? (w_grant ? VALID : IDLE) : (ack ? IDLE : VALID);
    end

    // A req bit set in the same cycle as its clear wins and stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_next;
            r_pending <= (r_pending & ~w_clr) | req;
            if (w_grant) r_idx <= w_index;
        end
    end

    assign idx     = r_idx;
    assign valid   = (r_state == VALID);
    assign pending = r_pending;
endmodule
